key_gesture_decoder: RTL and testbench
======================================

# key_gesture_decoder

Parametrised front-end that turns NUM_KEYS raw push-button inputs into debounced, duration-classified gesture events for the game controller. It handles tap/long-press classification, hold-type keys that are level-reported, and chord suppression, with a per-key mode mask. It sits between the board keys and the movement FSM. Its strobe and key index replace the old fixed 3-key movement code.

## Interface
- NUM_KEYS, 3: number of key inputs (≥2); KEY_W = max(1, clog2(NUM_KEYS)).
- CNT_W, 24: press-duration timer width.
- LONG_THRESH, 10_000_000: cycles at or above which a press is long. Must be ≤ 2^CNT_W−1.
- DEB_CYCLES, 4: consecutive stable cycles required to accept a level change. Must be ≥1.
- HOLD_MASK, 3'b010: per-key mode. 1 = hold (level-reported), 0 = tap (event on release).
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- inputkeys  in  NUM_KEYS  raw keys, active high, asynchronous to clk.
- evt_valid  out  1  one-cycle gesture strobe.
- evt_key  out  KEY_W  index of gesture key; meaningful with evt_valid.
- evt_long  out  1  1 = long press, 0 = short; meaningful with evt_valid.
- hold_active  out  1  a hold-mode key is currently held.
- hold_key  out  KEY_W  index of held key; meaningful with hold_active.
- busy  out  1  FSM not in IDLE.

## Operation
- Input stage: per key, 2-flop synchroniser s1→s2, then debounce.
  - Debounce counter cnt[i] (clog2(DEB_CYCLES+1) bits) clears whenever s2[i]==db[i].
  - While they differ, cnt[i] increments. When cnt[i]==DEB_CYCLES−1 and they still differ, db[i]<=s2[i] and cnt[i]<=0.
- FSM states: IDLE, PRESS, EMIT, HOLD, LOCKOUT.
  - IDLE: if db is exactly one-hot with bit k, latch k and clear the timer. Go to HOLD if HOLD_MASK[k], else PRESS. A zero or multi-bit db stays in IDLE, so simultaneous chords are ignored.
  - PRESS: timer increments each cycle and saturates at 2^CNT_W−1 (no wrap). Other keys are ignored. When db[k]==0, go to EMIT.
  - EMIT: evt_valid=1, evt_long=(timer ≥ LONG_THRESH). Next state is IDLE if db==0, else LOCKOUT.
  - HOLD: hold_active=1, hold_key=k. When db[k]==0, go to IDLE if db==0, else LOCKOUT. No event is generated.
  - LOCKOUT: wait for db==0, then go to IDLE. Prevents a still-held second key from starting a gesture.
- evt_key and hold_key are driven from the latched k register. evt_long is registered at the PRESS→EMIT transition.
- All outputs are Moore: decoded from registered state and registers only. There is no combinational path from inputkeys.

## Timing
- Reset (asynchronous, any time): state=IDLE; s1, s2, db, cnt, timer, and k all cleared. Outputs then read evt_valid=0, evt_key=0, evt_long=0, hold_active=0, hold_key=0, busy=0.
- Reset mid-gesture: the gesture is discarded and no event fires. A key still held after reset release is debounced and starts a fresh gesture.
- Latency, with E0 = first edge sampling a new stable raw level:
  - db changes at edge E0+1+DEB_CYCLES.
  - The FSM changes state at E0+2+DEB_CYCLES.
  - A tap release therefore gives evt_valid high for exactly the one cycle following E0+2+DEB_CYCLES.
  - hold_active rises and falls on the same offset.
- Measured duration: timer equals the number of cycles spent in PRESS, i.e. the debounced high time. A press of exactly LONG_THRESH cycles is long.
- Pulses shorter than DEB_CYCLES consecutive cycles never change db and are invisible.
- Minimum event spacing: EMIT→IDLE→PRESS, so back-to-back taps are limited only by debounce.

## Test plan
All scenarios use NUM_KEYS=3, CNT_W=4, LONG_THRESH=8, DEB_CYCLES=2, HOLD_MASK=3'b010.
- Tap: key0 high 5 cycles → one evt_valid pulse at E0+4 after the release sample, evt_key=0, evt_long=0, busy back to 0.
- Long and saturation: key2 high 20 cycles → single evt_valid, evt_key=2, evt_long=1. Timer stops at 15 and does not wrap.
- Threshold edge: key0 held so that PRESS lasts exactly 8 cycles → evt_long=1. With 7 cycles → evt_long=0.
- Hold: key1 high 10 cycles → hold_active high 10 consecutive cycles, hold_key=1, evt_valid never asserted.
- Glitch and chord: key0 1-cycle glitch → no activity. Key0 and key2 rising in the same cycle → stays IDLE, no event. Key0 pressed, then key2 pressed, then key0 released → one event for key0, then LOCKOUT (busy=1) until key2 releases, with no key2 event.
- Reset: reset asserted mid-PRESS on key0 → all outputs 0 immediately. Key0 released after reset → no evt_valid.

Source files
------------

// File: rtl/key_gesture_decoder.sv
// Debounced key front-end: classifies single-key presses as tap/long events
// or level-reported holds, and ignores chords until every key is released.
module key_gesture_decoder #(
  parameter int                  NUM_KEYS    = 3,
  parameter int                  CNT_W       = 24,
  parameter int                  LONG_THRESH = 10_000_000,
  parameter int                  DEB_CYCLES  = 4,
  parameter logic [NUM_KEYS-1:0] HOLD_MASK   = 3'b010,
  localparam int                 KEY_W       = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] inputkeys,
  output logic                evt_valid,
  output logic [KEY_W-1:0]    evt_key,
  output logic                evt_long,
  output logic                hold_active,
  output logic [KEY_W-1:0]    hold_key,
  output logic                busy
);

  localparam int              DCW       = $clog2(DEB_CYCLES + 1);
  localparam logic [DCW-1:0]  DEB_LAST  = DCW'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMER_MAX = '1;
  localparam logic [CNT_W-1:0] LONG_T    = CNT_W'(LONG_THRESH);

  typedef enum logic [2:0] {IDLE, PRESS, EMIT, HOLD, LOCKOUT} state_t;

  logic [NUM_KEYS-1:0] s1, s2, db;
  logic [DCW-1:0]      cnt [NUM_KEYS];

  state_t              state, state_nxt;
  logic [KEY_W-1:0]    key_q, key_nxt, hot_idx;
  logic [CNT_W-1:0]    timer, timer_nxt, timer_inc;
  logic                long_q, long_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= inputkeys;
      s2 <= s1;
    end
  end

  // A level change is accepted only after DEB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db <= '0;
      for (int i = 0; i < NUM_KEYS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (s2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DEB_LAST) begin
          db[i]  <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + DCW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      key_q  <= '0;
      timer  <= '0;
      long_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      key_q  <= key_nxt;
      timer  <= timer_nxt;
      long_q <= long_nxt;
    end
  end

  always_comb begin
    hot_idx = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (db[i]) hot_idx = KEY_W'(i);
    end
  end

  assign timer_inc = (timer == TIMER_MAX) ? timer : timer + CNT_W'(1);

  // The timer also counts the release cycle, so it equals the cycles spent in PRESS.
  always_comb begin
    state_nxt = state;
    key_nxt   = key_q;
    timer_nxt = timer;
    long_nxt  = long_q;
    case (state)
      IDLE: begin
        if ($onehot(db)) begin
          key_nxt   = hot_idx;
          timer_nxt = '0;
          state_nxt = HOLD_MASK[hot_idx] ? HOLD : PRESS;
        end
      end
      PRESS: begin
        timer_nxt = timer_inc;
        if (!db[key_q]) begin
          state_nxt = EMIT;
          long_nxt  = (timer_inc >= LONG_T);
        end
      end
      EMIT: begin
        state_nxt = (db == '0) ? IDLE : LOCKOUT;
      end
      HOLD: begin
        if (!db[key_q]) state_nxt = (db == '0) ? IDLE : LOCKOUT;
      end
      LOCKOUT: begin
        if (db == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign evt_valid   = (state == EMIT);
  assign evt_long    = (state == EMIT) && long_q;
  assign evt_key     = key_q;
  assign hold_active = (state == HOLD);
  assign hold_key    = key_q;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_key_gesture_decoder.sv
// Randomized and directed bench for key_gesture_decoder, checked every cycle
// against a gesture-level reference model.
module tb_key_gesture_decoder;

  localparam int             NK      = 3;
  localparam int             CW      = 4;
  localparam int             LONG_T  = 8;
  localparam int             DEB     = 2;
  localparam logic [NK-1:0]  HMASK   = 3'b010;
  localparam int             MAXT    = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NK-1:0] inputkeys = '0;
  logic          evt_valid, evt_long, hold_active, busy;
  logic [1:0]    evt_key, hold_key;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  key_gesture_decoder #(
    .NUM_KEYS(NK), .CNT_W(CW), .LONG_THRESH(LONG_T),
    .DEB_CYCLES(DEB), .HOLD_MASK(HMASK)
  ) dut (
    .clk(clk), .reset(rst_n), .inputkeys(inputkeys),
    .evt_valid(evt_valid), .evt_key(evt_key), .evt_long(evt_long),
    .hold_active(hold_active), .hold_key(hold_key), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog expired got=timeout want=finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s got=%0d want=%0d at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  // Reference model: a key's debounced level flips once the last DEB raw samples
  // (seen through the two-sample synchroniser delay) all disagree with it.
  logic [NK-1:0] hist [0:DEB];
  logic [NK-1:0] db_m;
  bit            active, is_hold, emit_now, emit_long, locked, flip;
  int            key_m, press_len;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j <= DEB; j++) hist[j] = '0;
      db_m = '0; active = 0; is_hold = 0; emit_now = 0; emit_long = 0;
      locked = 0; key_m = 0; press_len = 0;
    end else begin
      if (emit_now) begin
        emit_now = 0;
        locked   = (db_m != '0);
      end else if (active) begin
        if (!is_hold) press_len = (press_len < MAXT) ? press_len + 1 : MAXT;
        if (!db_m[key_m]) begin
          active = 0;
          if (is_hold) locked = (db_m != '0);
          else begin
            emit_now  = 1;
            emit_long = (press_len >= LONG_T);
          end
        end
      end else if (locked) begin
        if (db_m == '0) locked = 0;
      end else if ($countones(db_m) == 1) begin
        for (int i = 0; i < NK; i++) if (db_m[i]) key_m = i;
        active    = 1;
        is_hold   = HMASK[key_m];
        press_len = 0;
      end
      for (int i = 0; i < NK; i++) begin
        flip = 1;
        for (int j = 1; j <= DEB; j++) if (hist[j][i] == db_m[i]) flip = 0;
        if (flip) db_m[i] = ~db_m[i];
      end
      for (int j = DEB; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = inputkeys;
    end
  end

  always @(negedge clk) begin
    checkOutput("busy", int'(busy), int'(active || emit_now || locked));
    checkOutput("evt_valid", int'(evt_valid), int'(emit_now));
    checkOutput("hold_active", int'(hold_active), int'(active && is_hold));
    if (emit_now) begin
      checkOutput("evt_key", int'(evt_key), key_m);
      checkOutput("evt_long", int'(evt_long), int'(emit_long));
    end
    if (active && is_hold) checkOutput("hold_key", int'(hold_key), key_m);
  end

  // Activity counters used by the directed literal checks.
  int n_evt = 0, n_hold = 0, n_busy = 0, last_key = -1, last_long = -1;
  int evt_cyc = 0, last_hkey = -1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (evt_valid) begin
        n_evt++;
        last_key  = int'(evt_key);
        last_long = int'(evt_long);
        evt_cyc   = cyc;
      end
      if (hold_active) begin
        n_hold++;
        last_hkey = int'(hold_key);
      end
      if (busy) n_busy++;
    end
  end

  task automatic clearCounts();
    n_evt = 0; n_hold = 0; n_busy = 0; last_key = -1; last_long = -1; last_hkey = -1;
  endtask

  // Entered and left 2 time units after a rising edge; keys are sampled by exactly n edges.
  task automatic applyStimulus(input logic [NK-1:0] keys, input int n);
    inputkeys = keys;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_evt_valid"}, int'(evt_valid), 0);
    checkOutput({tag, "_evt_key"}, int'(evt_key), 0);
    checkOutput({tag, "_evt_long"}, int'(evt_long), 0);
    checkOutput({tag, "_hold_active"}, int'(hold_active), 0);
    checkOutput({tag, "_hold_key"}, int'(hold_key), 0);
    checkOutput({tag, "_busy"}, int'(busy), 0);
  endtask

  int rel_cyc;
  int r;
  logic [NK-1:0] pick;

  initial begin
    #1;
    checkAllZero("reset");
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    applyStimulus('0, 4);

    clearCounts();
    applyStimulus(3'b001, 5);
    rel_cyc = cyc;
    applyStimulus('0, 10);
    checkOutput("tap_count", n_evt, 1);
    checkOutput("tap_key", last_key, 0);
    checkOutput("tap_long", last_long, 0);
    checkOutput("tap_latency", evt_cyc - rel_cyc, 5);
    checkOutput("tap_busy_after", int'(busy), 0);

    clearCounts();
    applyStimulus(3'b100, 20);
    applyStimulus('0, 10);
    checkOutput("long_count", n_evt, 1);
    checkOutput("long_key", last_key, 2);
    checkOutput("long_sat", last_long, 1);

    clearCounts();
    applyStimulus(3'b001, 8);
    applyStimulus('0, 10);
    checkOutput("thresh8_long", last_long, 1);
    clearCounts();
    applyStimulus(3'b001, 7);
    applyStimulus('0, 10);
    checkOutput("thresh7_long", last_long, 0);

    clearCounts();
    applyStimulus(3'b010, 10);
    applyStimulus('0, 10);
    checkOutput("hold_cycles", n_hold, 10);
    checkOutput("hold_key_val", last_hkey, 1);
    checkOutput("hold_no_evt", n_evt, 0);

    clearCounts();
    applyStimulus(3'b001, 1);
    applyStimulus('0, 8);
    checkOutput("glitch_busy", n_busy, 0);

    clearCounts();
    applyStimulus(3'b101, 10);
    applyStimulus('0, 8);
    checkOutput("chord_busy", n_busy, 0);
    checkOutput("chord_evt", n_evt, 0);

    clearCounts();
    applyStimulus(3'b001, 6);
    applyStimulus(3'b101, 6);
    applyStimulus(3'b100, 10);
    checkOutput("seq_lockout_busy", int'(busy), 1);
    checkOutput("seq_count", n_evt, 1);
    checkOutput("seq_key", last_key, 0);
    applyStimulus('0, 10);
    checkOutput("seq_no_key2_evt", n_evt, 1);
    checkOutput("seq_busy_after", int'(busy), 0);

    applyStimulus(3'b001, 8);
    rst_n = 1'b0;
    #1;
    checkAllZero("midreset");
    clearCounts();
    inputkeys = '0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    applyStimulus('0, 10);
    checkOutput("midreset_no_evt", n_evt, 0);

    for (int k = 0; k < 160; k++) begin
      r = $urandom_range(0, 9);
      if (r < 4)       pick = '0;
      else if (r < 8)  pick = NK'(1 << $urandom_range(0, NK - 1));
      else             pick = NK'($urandom_range(0, (1 << NK) - 1));
      applyStimulus(pick, $urandom_range(1, 22));
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b0;
        applyStimulus(pick, $urandom_range(1, 3));
        rst_n = 1'b1;
      end
    end
    applyStimulus('0, 12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
